// File: rtl/cpu_mem_arbiter.sv
// cpu_mem_arbiter: serializes the core's instruction and data ports onto one
// registered downstream memory port and returns single-cycle responses.
// Optional feature: define ARB_FAIR_EN for round-robin arbitration on conflict;
// otherwise data has fixed priority over inst.
module cpu_mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_read,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  output logic        inst_resp,
  input  logic        data_read,
  input  logic        data_write,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_mbe,
  output logic [31:0] data_rdata,
  output logic        data_resp,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_mbe,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp,
  output logic        timeout_err
);

  localparam int unsigned CNT_W      = 16;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] INST_ABORT = 32'h0000_0013;
  localparam logic [31:0] DATA_ABORT = 32'h0000_0000;
  localparam logic [31:0] WORD_MASK  = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, RESP} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_mbe_q, mem_mbe_d;
  logic [31:0]       inst_rdata_q, inst_rdata_d;
  logic [31:0]       data_rdata_q, data_rdata_d;
  logic              inst_resp_q, inst_resp_d;
  logic              data_resp_q, data_resp_d;
  logic              timeout_err_q, timeout_err_d;

  logic              data_req_c;
  logic              grant_data_c;

  assign data_req_c = data_read | data_write;

`ifdef ARB_FAIR_EN
  // 1 = data port won the most recent grant; reset value means inst
  logic last_data_q, last_data_d;

  // On conflict, grant whichever port did not win last time
  assign grant_data_c = data_req_c & (~inst_read | ~last_data_q);
`else
  // Data always wins a conflict
  assign grant_data_c = data_req_c;
`endif

  // Next-state and registered-output computation
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    mem_read_d    = mem_read_q;
    mem_write_d   = mem_write_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    mem_mbe_d     = mem_mbe_q;
    inst_rdata_d  = inst_rdata_q;
    data_rdata_d  = data_rdata_q;
    inst_resp_d   = 1'b0;
    data_resp_d   = 1'b0;
    timeout_err_d = timeout_err_q;
`ifdef ARB_FAIR_EN
    last_data_d   = last_data_q;
`endif

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (data_req_c || inst_read) begin
`ifdef ARB_FAIR_EN
          last_data_d = grant_data_c;
`endif
          if (grant_data_c) begin
            // A simultaneous read+write is treated as a write
            mem_write_d = data_write;
            mem_read_d  = ~data_write;
            mem_addr_d  = data_addr & WORD_MASK;
            mem_wdata_d = data_wdata;
            mem_mbe_d   = data_write ? data_mbe : 4'hF;
            state_d     = SERVE_D;
          end else begin
            mem_write_d = 1'b0;
            mem_read_d  = 1'b1;
            mem_addr_d  = inst_addr & WORD_MASK;
            mem_wdata_d = '0;
            mem_mbe_d   = 4'hF;
            state_d     = SERVE_I;
          end
        end
      end

      SERVE_I, SERVE_D: begin
        if (mem_resp) begin
          // A response on the limit cycle still wins over the abort
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          if (!mem_write_q) begin
            if (state_q == SERVE_I) inst_rdata_d = mem_rdata;
            else                    data_rdata_d = mem_rdata;
          end
          inst_resp_d = (state_q == SERVE_I);
          data_resp_d = (state_q == SERVE_D);
          state_d     = RESP;
        end else if (cnt_q == CNT_LIMIT) begin
          mem_read_d    = 1'b0;
          mem_write_d   = 1'b0;
          timeout_err_d = 1'b1;
          if (state_q == SERVE_I) inst_rdata_d = INST_ABORT;
          else                    data_rdata_d = DATA_ABORT;
          inst_resp_d   = (state_q == SERVE_I);
          data_resp_d   = (state_q == SERVE_D);
          state_d       = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_mbe_q     <= '0;
      inst_rdata_q  <= '0;
      data_rdata_q  <= '0;
      inst_resp_q   <= 1'b0;
      data_resp_q   <= 1'b0;
      timeout_err_q <= 1'b0;
`ifdef ARB_FAIR_EN
      last_data_q   <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_mbe_q     <= mem_mbe_d;
      inst_rdata_q  <= inst_rdata_d;
      data_rdata_q  <= data_rdata_d;
      inst_resp_q   <= inst_resp_d;
      data_resp_q   <= data_resp_d;
      timeout_err_q <= timeout_err_d;
`ifdef ARB_FAIR_EN
      last_data_q   <= last_data_d;
`endif
    end
  end

  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_mbe     = mem_mbe_q;
  assign inst_rdata  = inst_rdata_q;
  assign data_rdata  = data_rdata_q;
  assign inst_resp   = inst_resp_q;
  assign data_resp   = data_resp_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Directed testbench for cpu_mem_arbiter (TIMEOUT_CYCLES = 4).
module tb_cpu_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        inst_read;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        inst_resp;
  logic        data_read;
  logic        data_write;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_mbe;
  logic [31:0] data_rdata;
  logic        data_resp;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_mbe;
  logic [31:0] mem_rdata;
  logic        mem_resp;
  logic        timeout_err;

  int tests_run    = 0;
  int tests_failed = 0;

  cpu_mem_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .inst_read   (inst_read),
    .inst_addr   (inst_addr),
    .inst_rdata  (inst_rdata),
    .inst_resp   (inst_resp),
    .data_read   (data_read),
    .data_write  (data_write),
    .data_addr   (data_addr),
    .data_wdata  (data_wdata),
    .data_mbe    (data_mbe),
    .data_rdata  (data_rdata),
    .data_resp   (data_resp),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_mbe     (mem_mbe),
    .mem_rdata   (mem_rdata),
    .mem_resp    (mem_resp),
    .timeout_err (timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    inst_read = 1'b0; inst_addr = '0;
    data_read = 1'b0; data_write = 1'b0; data_addr = '0;
    data_wdata = '0; data_mbe = '0;
    mem_rdata = '0; mem_resp = 1'b0;
    #1 rst = 1'b0;
    #12;
    tests_run++;
    if ({mem_read, mem_write, inst_resp, data_resp, timeout_err} !== 5'b0) begin
      $display("FAIL reset_flags: got %b exp 00000", {mem_read, mem_write, inst_resp, data_resp, timeout_err});
      tests_failed++;
    end
    tests_run++;
    if ({mem_addr, mem_wdata, mem_mbe} !== 68'h0) begin
      $display("FAIL reset_mem_bus: got %h exp 0", {mem_addr, mem_wdata, mem_mbe});
      tests_failed++;
    end
    tests_run++;
    if ({inst_rdata, data_rdata} !== 64'h0) begin
      $display("FAIL reset_rdata: got %h exp 0", {inst_rdata, data_rdata});
      tests_failed++;
    end
    @(posedge clk); #1;
    rst = 1'b1;
    tick();
    tests_run++;
    if (mem_read !== 1'b0) begin
      $display("FAIL reset_idle: mem_read got %b exp 0", mem_read);
      tests_failed++;
    end
  endtask

  task automatic test_single_fetch();
    inst_read = 1'b1; inst_addr = 32'h60;
    tick();
    tests_run++;
    if ({mem_read, mem_write, mem_addr, mem_mbe} !== {1'b1, 1'b0, 32'h60, 4'hF}) begin
      $display("FAIL fetch_req: got rd=%b wr=%b addr=%h mbe=%h exp rd=1 wr=0 addr=60 mbe=f", mem_read, mem_write, mem_addr, mem_mbe);
      tests_failed++;
    end
    tick();
    tests_run++;
    if ({mem_read, inst_resp} !== 2'b10) begin
      $display("FAIL fetch_wait: got rd=%b resp=%b exp rd=1 resp=0", mem_read, inst_resp);
      tests_failed++;
    end
    mem_resp = 1'b1; mem_rdata = 32'h00A0_0093;
    tick();
    mem_resp = 1'b0; inst_read = 1'b0;
    tests_run++;
    if ({inst_resp, data_resp, mem_read, inst_rdata} !== {3'b100, 32'h00A0_0093}) begin
      $display("FAIL fetch_resp: got iresp=%b dresp=%b rd=%b rdata=%h exp 1 0 0 00a00093", inst_resp, data_resp, mem_read, inst_rdata);
      tests_failed++;
    end
    tick();
    tests_run++;
    if ({inst_resp, inst_rdata} !== {1'b0, 32'h00A0_0093}) begin
      $display("FAIL fetch_hold: got resp=%b rdata=%h exp 0 00a00093", inst_resp, inst_rdata);
      tests_failed++;
    end
  endtask

  task automatic test_store();
    data_write = 1'b1; data_addr = 32'h1003; data_mbe = 4'b1000; data_wdata = 32'hAB00_0000;
    tick();
    tests_run++;
    if ({mem_write, mem_read, mem_addr, mem_mbe, mem_wdata} !== {2'b10, 32'h1000, 4'b1000, 32'hAB00_0000}) begin
      $display("FAIL store_req: got wr=%b rd=%b addr=%h mbe=%b wdata=%h exp 1 0 1000 1000 ab000000", mem_write, mem_read, mem_addr, mem_mbe, mem_wdata);
      tests_failed++;
    end
    data_wdata = 32'h1111_1111; data_mbe = 4'b0001;
    tick();
    tests_run++;
    if ({mem_write, mem_wdata, mem_mbe} !== {1'b1, 32'hAB00_0000, 4'b1000}) begin
      $display("FAIL store_stable: got wr=%b wdata=%h mbe=%b exp 1 ab000000 1000", mem_write, mem_wdata, mem_mbe);
      tests_failed++;
    end
    mem_resp = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_resp = 1'b0; data_write = 1'b0;
    tests_run++;
    if ({data_resp, inst_resp, mem_write, data_rdata} !== {3'b100, 32'h0}) begin
      $display("FAIL store_resp: got dresp=%b iresp=%b wr=%b rdata=%h exp 1 0 0 00000000", data_resp, inst_resp, mem_write, data_rdata);
      tests_failed++;
    end
    tick();
    tests_run++;
    if (data_resp !== 1'b0) begin
      $display("FAIL store_pulse: data_resp got %b exp 0", data_resp);
      tests_failed++;
    end
  endtask

  task automatic test_conflict();
    logic [31:0] exp_addr [3];
    int n;
    exp_addr[0] = 32'h200;
`ifdef ARB_FAIR_EN
    exp_addr[1] = 32'h100;
`else
    exp_addr[1] = 32'h200;
`endif
    exp_addr[2] = 32'h200;
    inst_read = 1'b1; inst_addr = 32'h100;
    data_read = 1'b1; data_addr = 32'h200;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (!mem_read && n < 10) begin
        tick();
        n++;
      end
      tests_run++;
      if (!mem_read || mem_addr !== exp_addr[k]) begin
        $display("FAIL conflict_grant%0d: got rd=%b addr=%h exp rd=1 addr=%h", k, mem_read, mem_addr, exp_addr[k]);
        tests_failed++;
      end
      mem_resp = 1'b1; mem_rdata = 32'hC0DE_0000 + 32'(k);
      tick();
      mem_resp = 1'b0;
      tests_run++;
      if ({inst_resp, data_resp} !== {exp_addr[k] == 32'h100, exp_addr[k] == 32'h200}) begin
        $display("FAIL conflict_resp%0d: got iresp=%b dresp=%b exp grant addr %h", k, inst_resp, data_resp, exp_addr[k]);
        tests_failed++;
      end
      if (k == 2) begin
        inst_read = 1'b0; data_read = 1'b0;
      end
      tick();
    end
    tests_run++;
    if (data_rdata !== 32'hC0DE_0002) begin
      $display("FAIL conflict_rdata: got %h exp c0de0002", data_rdata);
      tests_failed++;
    end
  endtask

  task automatic test_back_to_back();
    data_read = 1'b1; data_addr = 32'h500;
    mem_resp = 1'b1; mem_rdata = 32'h0000_0055;
    for (int i = 1; i <= 8; i++) begin
      tick();
      tests_run++;
      if ({data_resp, mem_read} !== {i % 3 == 2, i % 3 == 1}) begin
        $display("FAIL b2b_cycle%0d: got dresp=%b rd=%b exp %b %b", i, data_resp, mem_read, i % 3 == 2, i % 3 == 1);
        tests_failed++;
      end
      if (i == 8) begin
        data_read = 1'b0; mem_resp = 1'b0;
      end
    end
    tick();
  endtask

  task automatic test_boundary();
    mem_resp = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    tick();
    mem_resp = 1'b0;
    tests_run++;
    if ({inst_resp, data_resp, mem_read} !== 3'b000) begin
      $display("FAIL idle_resp_ignored: got %b exp 000", {inst_resp, data_resp, mem_read});
      tests_failed++;
    end
    data_read = 1'b1; data_addr = 32'h2000;
    tick(); tick(); tick(); tick();
    tests_run++;
    if ({mem_read, data_resp} !== 2'b10) begin
      $display("FAIL boundary_serve4: got rd=%b dresp=%b exp 1 0", mem_read, data_resp);
      tests_failed++;
    end
    mem_resp = 1'b1; mem_rdata = 32'h1234_5678;
    tick();
    mem_resp = 1'b0; data_read = 1'b0;
    tests_run++;
    if ({data_resp, timeout_err, data_rdata} !== {2'b10, 32'h1234_5678}) begin
      $display("FAIL boundary_resp: got dresp=%b terr=%b rdata=%h exp 1 0 12345678", data_resp, timeout_err, data_rdata);
      tests_failed++;
    end
    tick();
  endtask

  task automatic test_timeout();
    int serve;
    int n;
    serve = 0; n = 0;
    inst_read = 1'b1; inst_addr = 32'h400;
    tick();
    tests_run++;
    if (timeout_err !== 1'b0) begin
      $display("FAIL timeout_pre: terr got %b exp 0", timeout_err);
      tests_failed++;
    end
    while (!inst_resp && n < 12) begin
      if (mem_read) serve++;
      tick();
      n++;
    end
    inst_read = 1'b0;
    tests_run++;
    if (serve !== 4) begin
      $display("FAIL timeout_cycles: got %0d serve cycles exp 4", serve);
      tests_failed++;
    end
    tests_run++;
    if ({inst_resp, mem_read, timeout_err, inst_rdata} !== {3'b101, 32'h0000_0013}) begin
      $display("FAIL timeout_resp: got iresp=%b rd=%b terr=%b rdata=%h exp 1 0 1 00000013", inst_resp, mem_read, timeout_err, inst_rdata);
      tests_failed++;
    end
    tick(); tick();
    tests_run++;
    if ({timeout_err, inst_resp} !== 2'b10) begin
      $display("FAIL timeout_sticky: got terr=%b iresp=%b exp 1 0", timeout_err, inst_resp);
      tests_failed++;
    end
  endtask

  task automatic test_reset_mid();
    data_read = 1'b1; data_addr = 32'h3000;
    tick();
    tests_run++;
    if ({mem_read, mem_addr} !== {1'b1, 32'h3000}) begin
      $display("FAIL rstmid_serve: got rd=%b addr=%h exp 1 3000", mem_read, mem_addr);
      tests_failed++;
    end
    #2 rst = 1'b0;
    #1;
    tests_run++;
    if ({mem_read, mem_write, data_resp, inst_resp, timeout_err} !== 5'b0) begin
      $display("FAIL rstmid_flags: got %b exp 00000", {mem_read, mem_write, data_resp, inst_resp, timeout_err});
      tests_failed++;
    end
    tests_run++;
    if ({mem_addr, mem_wdata, mem_mbe, inst_rdata, data_rdata} !== 132'h0) begin
      $display("FAIL rstmid_data: got %h exp 0", {mem_addr, mem_wdata, mem_mbe, inst_rdata, data_rdata});
      tests_failed++;
    end
    data_read = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    tests_run++;
    if ({data_resp, mem_read} !== 2'b00) begin
      $display("FAIL rstmid_no_resp: got dresp=%b rd=%b exp 0 0", data_resp, mem_read);
      tests_failed++;
    end
    data_read = 1'b1; data_addr = 32'h3004;
    tick();
    tests_run++;
    if ({mem_read, mem_addr} !== {1'b1, 32'h3004}) begin
      $display("FAIL rstmid_regrant: got rd=%b addr=%h exp 1 3004", mem_read, mem_addr);
      tests_failed++;
    end
    mem_resp = 1'b1; mem_rdata = 32'h0000_0077;
    tick();
    mem_resp = 1'b0; data_read = 1'b0;
    tests_run++;
    if ({data_resp, data_rdata} !== {1'b1, 32'h77}) begin
      $display("FAIL rstmid_resp: got dresp=%b rdata=%h exp 1 00000077", data_resp, data_rdata);
      tests_failed++;
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_store();
    test_conflict();
    test_back_to_back();
    test_boundary();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/cpu_mem_arbiter.md
# cpu_mem_arbiter

Memory-side responder for the pipelined RV32I core's split instruction and data ports. Accepts `inst_*` and `data_*` requests, serializes them onto one downstream memory port (`mem_*`), and returns a single-cycle `*_resp` with read data to the requesting port. Sits between the core and the cache/physical-memory hierarchy. Holds every downstream signal in registers, so `mem_*` outputs stay stable for the whole transaction.

## Interface
- `TIMEOUT_CYCLES`, default 1023: cycles in a serve state without `mem_resp` before the transaction is aborted; legal range 1..65535.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous assert, active-low.
- `inst_read`  in  1  instruction fetch request; held until `inst_resp`.
- `inst_addr`  in  32  fetch byte address.
- `inst_rdata`  out  32  fetched word; valid in the `inst_resp` cycle; held afterwards.
- `inst_resp`  out  1  one-cycle completion pulse.
- `data_read`  in  1  load request.
- `data_write`  in  1  store request.
- `data_addr`  in  32  load/store byte address.
- `data_wdata`  in  32  store data, already lane-shifted.
- `data_mbe`  in  4  store byte enables.
- `data_rdata`  out  32  load word; valid in the `data_resp` cycle; held afterwards.
- `data_resp`  out  1  one-cycle completion pulse.
- `mem_read` / `mem_write`  out  1  downstream request; held until `mem_resp`.
- `mem_addr`  out  32  `{addr[31:2],2'b00}` of the granted request.
- `mem_wdata`  out  32  latched store data.
- `mem_mbe`  out  4  latched byte enables; `4'hF` for reads.
- `mem_rdata`  in  32  downstream read data; valid when `mem_resp` is high.
- `mem_resp`  in  1  downstream completion.
- `timeout_err`  out  1  sticky flag; set on any abort.

## Operation
- States: IDLE, SERVE_I, SERVE_D, RESP.
- **IDLE**
  - A data request is pending when `data_read | data_write`.
  - If only one port is pending, grant it.
  - If both are pending, resolve per the arbitration policy (see Configuration).
  - On grant, latch into registers: port id, op, word-aligned address, wdata, mbe. Go to SERVE_I or SERVE_D.
  - If `data_read` and `data_write` are both high, treat the request as a write.
- **SERVE_x**
  - Drive `mem_read` or `mem_write` from the latched op.
  - On `mem_resp`:
    - Reads: capture `mem_rdata` into the granted port's rdata register.
    - Writes: leave `data_rdata` unchanged.
    - Go to RESP.
  - The wait counter clears on entry and increments every SERVE cycle without `mem_resp`.
  - When the counter reaches `TIMEOUT_CYCLES`:
    - Set `timeout_err`.
    - Load rdata with the abort value: `32'h0000_0013` (NOP) for inst, `32'h0` for data.
    - Go to RESP.
    - `mem_read`/`mem_write` drop the next cycle.
- **RESP**
  - Assert the granted port's `*_resp` for exactly one cycle, then return to IDLE.
  - `mem_read`/`mem_write` are low in RESP.
- **Requester rule:** a request still asserted when IDLE is re-entered is a new request. The core must drop it in the cycle after `*_resp` unless it issues another.
- Only one `*_resp` is ever high in a given cycle. Ungranted requests wait in place; there is no queuing beyond one outstanding transaction.
- `timeout_err` clears only on reset.

## Timing
- Reset values:
  - state = IDLE.
  - All outputs 0, including `inst_rdata`, `data_rdata`, `timeout_err`.
  - Wait counter = 0.
  - Last-grant register = inst.
- Reset mid-transaction: the transaction is abandoned immediately. No `*_resp` is issued and downstream requests drop asynchronously.
- Latency:
  - Request sampled in IDLE at edge N → `mem_*` asserted in cycle N+1.
  - `mem_resp` sampled at edge M → `*_resp` in cycle M+1 → IDLE at M+2.
  - Minimum request-to-resp time: 2 cycles, with `mem_resp` in the first serve cycle.
  - Back-to-back transactions on the same port: one every 3 cycles minimum.
- `mem_addr`, `mem_wdata`, `mem_mbe` change only on the IDLE→SERVE edge.
- A `mem_resp` arriving in the same cycle the counter hits the limit wins: the read data is captured and no error is flagged.
- `mem_resp` while in IDLE or RESP is ignored.

## Configuration
- `ARB_FAIR_EN`
  - Defined: round-robin arbitration. On conflict, grant the port not granted last; the last-grant register updates on every grant.
  - Undefined: fixed priority, data before inst. The last-grant register is not instantiated.

## Test plan
- Single fetch: `inst_read`=1, `inst_addr`=0x60, `mem_resp` one cycle after `mem_read` with 0x00A00093. Expect `mem_addr`=0x60, `inst_resp` pulse, `inst_rdata`=0x00A00093.
- Store: `data_write`=1, `data_addr`=0x1003, `data_mbe`=4'b1000, `data_wdata`=0xAB000000. Expect `mem_addr`=0x1000, `mem_mbe`=4'b1000, `mem_wdata` stable until `mem_resp`, `data_resp` pulse, `data_rdata` unchanged.
- Conflict: `inst_read` and `data_read` held high together for 3 transactions.
  - Without `ARB_FAIR_EN`: grant order D, D, D while `data_read` stays high; I waits.
  - With `ARB_FAIR_EN`: grant order D, I, D.
- Timeout with `TIMEOUT_CYCLES`=4 and `mem_resp` never asserted on a fetch. Expect `inst_resp` after 4 serve cycles, `inst_rdata`=0x00000013, `timeout_err`=1 and sticky.
- Boundary: `mem_resp` exactly on the timeout cycle, read of 0x12345678. Expect `data_rdata`=0x12345678 and `timeout_err`=0.
- Reset: `rst` low during SERVE_D. Expect `mem_read` to drop immediately, no `data_resp`, all outputs 0, and a clean IDLE grant after release.
